// File: rtl/alux_pkg.sv
// Shared ALUX definitions: opcode tags, default result-FIFO depth and the entry-width helper.
package alux_pkg;

    localparam int unsigned OPR_W      = 4;
    localparam int unsigned ALUX_DEPTH = 8;

    typedef enum logic [OPR_W-1:0] {
        OPR_A   = 4'b0000,
        OPR_B   = 4'b0001,
        OPR_SUM = 4'b0010,
        OPR_SUB = 4'b0011
    } alux_opr_e;

    // Stored entry is {opcode tag, result}
    function automatic int unsigned entry_width(input int unsigned dw);
        return dw + OPR_W;
    endfunction

endpackage

// File: rtl/alux_fifo_mem.sv
// Result storage: synchronous-write, registered-read dual-port array (array itself is not reset).
module alux_fifo_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 68
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register holds the last popped entry; same-address write returns the old contents
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/alux_result_fifo.sv
// ALUX result FIFO: pushes {opr, outAB} on each rising edge of done, pops on rd_en.
// Optional overflow tracking (ovf, drop_cnt) is built only when ALUX_FIFO_OVF_EN is defined.
module alux_result_fifo
    import alux_pkg::*;
#(
    parameter int unsigned DEPTH = ALUX_DEPTH,
    parameter int unsigned DW    = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   done,
    input  logic [DW-1:0]          outAB,
    input  logic [OPR_W-1:0]       opr,
    input  logic                   rd_en,
    output logic [DW-1:0]          rd_data,
    output logic [OPR_W-1:0]       rd_opr,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf,
    output logic [7:0]             drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = entry_width(DW);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          done_q;
    logic          armed;
    logic          push;
    logic          pop;
    logic          push_ok;
    logic [EW-1:0] rd_entry;

    // armed blocks a done level that was already high across reset from pushing
    assign push    = done & ~done_q & armed;
    assign pop     = rd_en & ~empty;
    assign push_ok = push & (~full | pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            done_q   <= 1'b0;
            armed    <= ~done;
            rd_valid <= 1'b0;
        end else begin
            done_q   <= done;
            armed    <= armed | ~done;
            rd_valid <= pop;
            if (push_ok) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    alux_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_mem (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data ({opr, outAB}),
        .rd_en   (pop),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_entry)
    );

    assign rd_data = rd_entry[DW-1:0];
    assign rd_opr  = rd_entry[EW-1:DW];

`ifdef ALUX_FIFO_OVF_EN
    logic drop;

    assign drop = push & full & ~pop;

    // Sticky overflow flag and saturating discard counter
    always_ff @(posedge clock) begin
        if (reset) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end
`else
    assign ovf      = 1'b0;
    assign drop_cnt = '0;
`endif

endmodule

// File: doc/alux_result_fifo.md
ALUX_RESULT_FIFO -- requirements
Module: alux_result_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of result entries (power of two, 2..64).
REQ-002 SHALL have parameter DW, default 64, ALU result width.
REQ-003 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port done  input  1  ALUX completion flag; a level signal that may stay high for several cycles.
REQ-006 SHALL have port outAB  input  DW  ALUX result, valid whenever done is high.
REQ-007 SHALL have port opr  input  4  operation code that produced outAB, stored as a tag.
REQ-008 SHALL have port rd_en  input  1  consumer pop request.
REQ-009 SHALL have port rd_data  output  DW  popped result.
REQ-010 SHALL have port rd_opr  output  4  popped opcode tag.
REQ-011 SHALL have port rd_valid  output  1  one-cycle strobe qualifying rd_data and rd_opr.
REQ-012 SHALL have port empty  output  1  no entries stored.
REQ-013 SHALL have port full  output  1  DEPTH entries stored.
REQ-014 SHALL have port count  output  log2(DEPTH)+1  current occupancy.
REQ-015 SHALL have port ovf  output  1  sticky flag set when a result is dropped.
REQ-016 SHALL have port drop_cnt  output  8  saturating count of dropped results.

Function
REQ-017 SHALL generate a push only on the cycle where done=1 and done was 0 in the previous cycle, so a long done level pushes exactly once.
REQ-018 SHALL write {opr, outAB}, sampled on the push cycle, at the write pointer and SHALL advance the write pointer modulo DEPTH.
REQ-019 SHALL accept a pop when rd_en=1 and empty=0; rd_data and rd_opr SHALL be registered, and rd_valid=1 SHALL appear exactly one cycle after the accepted pop.
REQ-020 SHALL ignore rd_en while empty=1; rd_valid stays 0 and the pointers stay unchanged.
REQ-021 SHALL hold rd_data and rd_opr at their last popped values when no pop occurs.
REQ-022 SHALL, when full, accept a push and a pop in the same cycle; count stays at DEPTH and no drop occurs.
REQ-023 SHALL, when empty, accept the push of a same-cycle push and pop and ignore the pop; count becomes 1.
REQ-024 SHALL, when full with no same-cycle pop, discard the push and leave the stored contents unchanged.
REQ-025 SHALL use pointers one bit wider than log2(DEPTH); empty is true when the pointers are equal, and full is true when the MSBs differ and the remaining bits are equal.
REQ-026 SHALL derive count, empty and full from registered pointers only, with no combinational path from done or rd_en.

Reset
REQ-027 SHALL, on reset, clear both pointers, count, rd_valid, ovf, drop_cnt, rd_data and rd_opr to 0, set empty=1 and full=0, and clear the done-edge history to 0.
REQ-028 SHALL let reset dominate a simultaneous push or pop; a done already high when reset deasserts SHALL NOT push until done falls and rises again.
REQ-029 SHALL NOT require the storage array to be reset.

Configuration
REQ-030 SHALL, with macro ALUX_FIFO_OVF_EN defined, set ovf on each discarded push and hold it until reset, and increment drop_cnt per discard, saturating at 255.
REQ-031 SHALL, without ALUX_FIFO_OVF_EN, tie ovf and drop_cnt to constant 0 and remove their logic; all other behaviour is unchanged.

Structure
REQ-032 SHALL take the opcode width (4), the default DEPTH (8), the entry width (DW+4) and the opcode constants A=0000, B=0001, SUM=0010 and SUB=0011 from the shared package alux_pkg.
REQ-033 SHALL place storage in one sub-module, alux_fifo_mem: a synchronous-write, registered-read dual-port array. Pointer, flag and edge-detect control SHALL stay in alux_result_fifo.

Verification
REQ-034 SHALL cover: reset, then a done pulse with outAB=64'h0000_0000_0000_0005 and opr=0010 -> count=1, empty=0; rd_en for one cycle -> next cycle rd_valid=1, rd_data=5, rd_opr=0010, empty=1.
REQ-035 SHALL cover: done held high for 6 cycles -> count=1 only.
REQ-036 SHALL cover: 8 pushes of values 1..8, then a 9th push of 9 -> full=1, count=8; the bench SHALL then drain all 8 entries -> reads 1..8 in order.
REQ-037 SHALL cover the 9th push of REQ-036 with ALUX_FIFO_OVF_EN defined -> ovf=1, drop_cnt=1; and without the macro -> ovf=0, drop_cnt=0.
REQ-038 SHALL cover: full FIFO with a simultaneous push of 64'hAA and a pop -> count stays 8, oldest entry returned, 64'hAA read last.
REQ-039 SHALL cover: reset asserted while count=5 and done=1 -> next cycle empty=1, count=0, and no push until done toggles low then high.
